// File: rtl/calc1_port_sched.sv
// calc1_port_sched: four-port request scheduler feeding one shared ALU.
// Optional macro CALC1_SCHED_INVALID_CMD_EN answers unsupported commands locally.
module calc1_port_sched #(
    parameter int NPORTS = 4,
    parameter int DW     = 32
) (
    input  logic                 c_clk,
    input  logic                 reset,
    input  logic [4*NPORTS-1:0]  req_cmd_in,
    input  logic [DW*NPORTS-1:0] req_data_in,
    output logic [2*NPORTS-1:0]  out_resp,
    output logic [DW*NPORTS-1:0] out_data,
    output logic                 alu_valid,
    input  logic                 alu_ready,
    output logic [3:0]           alu_cmd,
    output logic [DW-1:0]        alu_op1,
    output logic [DW-1:0]        alu_op2,
    output logic [1:0]           alu_tag,
    input  logic                 alu_rsp_valid,
    input  logic [1:0]           alu_rsp_tag,
    input  logic [1:0]           alu_rsp_code,
    input  logic [DW-1:0]        alu_rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        OP2,
        PEND,
        BUSY
    } state_t;

    state_t        state [NPORTS];
    logic [3:0]    cmd_q [NPORTS];
    logic [DW-1:0] op1_q [NPORTS];
    logic [DW-1:0] op2_q [NPORTS];

    logic [1:0] ptr;
    logic       lock;
    logic [1:0] lock_idx;
    logic [1:0] grant;
    logic       any_pend;
    logic [2:0] cand;
    logic       issue;

`ifdef CALC1_SCHED_INVALID_CMD_EN
    function automatic logic cmd_ok(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction
`endif

    // Round-robin pick over pending ports; a stalled grant stays locked.
    always_comb begin
        grant    = lock_idx;
        any_pend = lock;
        cand     = 3'd0;
        if (!lock) begin
            for (int i = 0; i < NPORTS; i++) begin
                cand = {1'b0, ptr} + 3'(i);
                if (cand >= 3'(NPORTS)) begin
                    cand = cand - 3'(NPORTS);
                end
                if (!any_pend && state[cand[1:0]] == PEND) begin
                    any_pend = 1'b1;
                    grant    = cand[1:0];
                end
            end
        end
    end

    // Issue payload is the granted port's captured operands, zero when idle.
    always_comb begin
        alu_valid = any_pend;
        alu_tag   = any_pend ? grant : 2'd0;
        alu_cmd   = any_pend ? cmd_q[grant] : 4'd0;
        alu_op1   = any_pend ? op1_q[grant] : '0;
        alu_op2   = any_pend ? op2_q[grant] : '0;
        issue     = any_pend && alu_ready;
    end

    // Per-port FSMs, arbitration pointer/lock and response registers.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            ptr      <= 2'd0;
            lock     <= 1'b0;
            lock_idx <= 2'd0;
            out_resp <= '0;
            out_data <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                state[i] <= IDLE;
                cmd_q[i] <= 4'd0;
                op1_q[i] <= '0;
                op2_q[i] <= '0;
            end
        end else begin
            lock     <= alu_valid && !alu_ready;
            lock_idx <= grant;
            if (issue) begin
                ptr <= (grant == 2'(NPORTS - 1)) ? 2'd0 : grant + 2'd1;
            end
            for (int i = 0; i < NPORTS; i++) begin
                out_resp[2*i +: 2] <= 2'd0;
                unique case (state[i])
                    IDLE: begin
                        if (req_cmd_in[4*i +: 4] != 4'd0) begin
                            cmd_q[i] <= req_cmd_in[4*i +: 4];
                            op1_q[i] <= req_data_in[DW*i +: DW];
                            state[i] <= OP2;
                        end
                    end
                    OP2: begin
                        op2_q[i] <= req_data_in[DW*i +: DW];
`ifdef CALC1_SCHED_INVALID_CMD_EN
                        if (cmd_ok(cmd_q[i])) begin
                            state[i] <= PEND;
                        end else begin
                            out_resp[2*i +: 2]  <= 2'd2;
                            out_data[DW*i +: DW] <= '0;
                            state[i] <= IDLE;
                        end
`else
                        state[i] <= PEND;
`endif
                    end
                    PEND: begin
                        if (issue && grant == 2'(i)) begin
                            state[i] <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (alu_rsp_valid && alu_rsp_tag == 2'(i)) begin
                            out_resp[2*i +: 2]   <= alu_rsp_code;
                            out_data[DW*i +: DW] <= alu_rsp_data;
                            state[i] <= IDLE;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc1_port_sched.sv
// tb_calc1_port_sched: vector table, directed corner sequences and a
// randomized run against a transaction-level scheduler/ALU model.
module tb_calc1_port_sched;

    localparam int NP = 4;
    localparam int DW = 32;

    logic            c_clk = 1'b0;
    logic            reset;
    logic [4*NP-1:0] req_cmd_in;
    logic [DW*NP-1:0] req_data_in;
    logic [2*NP-1:0] out_resp;
    logic [DW*NP-1:0] out_data;
    logic            alu_valid;
    logic            alu_ready;
    logic [3:0]      alu_cmd;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [1:0]      alu_tag;
    logic            alu_rsp_valid;
    logic [1:0]      alu_rsp_tag;
    logic [1:0]      alu_rsp_code;
    logic [DW-1:0]   alu_rsp_data;

    int errors = 0;
    int checks = 0;
    int issue_cnt = 0;
    int resp_cnt = 0;

    always #5 c_clk = ~c_clk;

    calc1_port_sched #(.NPORTS(NP), .DW(DW)) dut (
        .c_clk(c_clk),
        .reset(reset),
        .req_cmd_in(req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp(out_resp),
        .out_data(out_data),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_cmd(alu_cmd),
        .alu_op1(alu_op1),
        .alu_op2(alu_op2),
        .alu_tag(alu_tag),
        .alu_rsp_valid(alu_rsp_valid),
        .alu_rsp_tag(alu_rsp_tag),
        .alu_rsp_code(alu_rsp_code),
        .alu_rsp_data(alu_rsp_data)
    );

    // Issue and response pulse counters, sampled mid-cycle.
    always @(negedge c_clk) begin
        if (alu_valid && alu_ready) issue_cnt++;
        if (out_resp != '0) resp_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic clr();
        req_cmd_in    = '0;
        req_data_in   = '0;
        alu_rsp_valid = 1'b0;
        alu_rsp_tag   = 2'd0;
        alu_rsp_code  = 2'd0;
        alu_rsp_data  = '0;
    endtask

    task automatic set_port(input int p, input logic [3:0] c,
                            input logic [31:0] d);
        req_cmd_in[4*p +: 4]    = c;
        req_data_in[DW*p +: DW] = d;
    endtask

    task automatic rsp(input int t, input logic [1:0] c,
                       input logic [31:0] d);
        alu_rsp_valid = 1'b1;
        alu_rsp_tag   = 2'(t);
        alu_rsp_code  = c;
        alu_rsp_data  = d;
        tick();
        alu_rsp_valid = 1'b0;
    endtask

    function automatic logic [1:0] resp_of(input int p);
        return out_resp[2*p +: 2];
    endfunction

    function automatic logic [31:0] data_of(input int p);
        return out_data[DW*p +: DW];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        clr();
        alu_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        int         port;
        logic [3:0] cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0] code;
        logic [31:0] rdata;
        int         delay;
    } vec_t;

    vec_t vt[5];

    // Transaction-level model state for the randomized run.
    int          m_st [NP];
    logic [3:0]  m_cmd [NP];
    logic [31:0] m_op1 [NP];
    logic [31:0] m_op2 [NP];
    logic [1:0]  e_resp [NP];
    logic [31:0] e_data [NP];
    int          m_ptr;
    bit          m_lock;
    int          m_lidx;

    typedef struct {
        int         tag;
        int         due;
        logic [1:0] code;
        logic [31:0] data;
    } rsp_t;

    rsp_t aq[$];

    initial begin
        vt[0] = '{0, 4'd1, 32'hFFFF0000, 32'h0000FFFF, 2'd1, 32'hFFFFFFFF, 3};
        vt[1] = '{1, 4'd2, 32'h00000010, 32'h00000020, 2'd2, 32'hFFFFFFF0, 1};
        vt[2] = '{2, 4'd5, 32'h00000001, 32'h0000001F, 2'd1, 32'h80000000, 2};
        vt[3] = '{3, 4'd6, 32'h80000000, 32'h00000004, 2'd1, 32'h08000000, 0};
        vt[4] = '{0, 4'd2, 32'h12345678, 32'h9ABCDEF0, 2'd2, 32'h77777777, 4};

        reset     = 1'b1;
        alu_ready = 1'b1;
        clr();
        #2;
        chk("rst_valid", 32'(alu_valid), 0);
        chk("rst_cmd", 32'(alu_cmd), 0);
        chk("rst_op1", alu_op1, 0);
        chk("rst_op2", alu_op2, 0);
        chk("rst_tag", 32'(alu_tag), 0);
        chk("rst_resp", 32'(out_resp), 0);
        chk("rst_data_lo", out_data[63:0] == '0, 1);
        chk("rst_data_hi", out_data[127:64] == '0, 1);
        tick();
        reset = 1'b0;
        tick();

        // Table-driven single transactions.
        for (int v = 0; v < 5; v++) begin
            int p;
            p = vt[v].port;
            set_port(p, vt[v].cmd, vt[v].op1);
            tick();
            set_port(p, 4'd0, vt[v].op2);
            tick();
            set_port(p, 4'd0, 32'd0);
            chk("tbl_valid", 32'(alu_valid), 1);
            chk("tbl_cmd", 32'(alu_cmd), 32'(vt[v].cmd));
            chk("tbl_op1", alu_op1, vt[v].op1);
            chk("tbl_op2", alu_op2, vt[v].op2);
            chk("tbl_tag", 32'(alu_tag), 32'(p));
            tick();
            chk("tbl_valid_off", 32'(alu_valid), 0);
            repeat (vt[v].delay) tick();
            rsp(p, vt[v].code, vt[v].rdata);
            chk("tbl_resp", 32'(resp_of(p)), 32'(vt[v].code));
            chk("tbl_data", data_of(p), vt[v].rdata);
            chk("tbl_resp_other",
                32'(out_resp & ~(8'h3 << (2 * p))), 0);
            tick();
            chk("tbl_resp_pulse", 32'(out_resp), 0);
            chk("tbl_data_hold", data_of(p), vt[v].rdata);
        end

        // Contention: all four ports at once, pointer from reset.
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'h55555555);
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'hAAAAAAAA);
        tick();
        clr();
        for (int k = 0; k < NP; k++) begin
            chk("cont_valid", 32'(alu_valid), 1);
            chk("cont_tag", 32'(alu_tag), 32'(k));
            tick();
        end
        chk("cont_done", 32'(alu_valid), 0);
        for (int k = NP - 1; k >= 0; k--) begin
            rsp(k, 2'd1, 32'hFFFFFFF0 | 32'(k));
            chk("cont_resp", 32'(out_resp), 32'(8'h1 << (2 * k)));
            chk("cont_data", data_of(k), 32'hFFFFFFF0 | 32'(k));
        end

        // Stall: ports 2 and 3 pending with ready low.
        alu_ready = 1'b0;
        set_port(1, 4'd1, 32'h11110001);
        set_port(2, 4'd2, 32'h22220002);
        tick();
        set_port(1, 4'd0, 32'h0000000A);
        set_port(2, 4'd0, 32'h0000000B);
        tick();
        clr();
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", 32'(alu_valid), 1);
            chk("stall_tag", 32'(alu_tag), 1);
            chk("stall_op1", alu_op1, 32'h11110001);
            chk("stall_op2", alu_op2, 32'h0000000A);
            tick();
        end
        alu_ready = 1'b1;
        chk("stall_acc_tag", 32'(alu_tag), 1);
        tick();
        chk("stall_next_valid", 32'(alu_valid), 1);
        chk("stall_next_tag", 32'(alu_tag), 2);
        chk("stall_next_op1", alu_op1, 32'h22220002);
        tick();
        chk("stall_idle", 32'(alu_valid), 0);
        rsp(1, 2'd1, 32'h1);
        rsp(2, 2'd1, 32'h2);

        // Drop: second command while BUSY.
        tick();
        issue_cnt = 0;
        resp_cnt  = 0;
        set_port(0, 4'd1, 32'h7);
        tick();
        set_port(0, 4'd0, 32'h8);
        tick();
        clr();
        tick();
        set_port(0, 4'd2, 32'h99);
        tick();
        set_port(0, 4'd0, 32'h98);
        tick();
        clr();
        tick();
        tick();
        chk("drop_issue_busy", 32'(issue_cnt), 1);
        rsp(0, 2'd1, 32'hF);
        chk("drop_data", data_of(0), 32'hF);
        repeat (4) tick();
        chk("drop_issues", 32'(issue_cnt), 1);
        chk("drop_resps", 32'(resp_cnt), 1);

        // Reset while port4 is BUSY and port1 is stalled.
        set_port(3, 4'd1, 32'h3);
        tick();
        set_port(3, 4'd0, 32'h4);
        tick();
        clr();
        tick();
        alu_ready = 1'b0;
        set_port(0, 4'd2, 32'hABCD);
        tick();
        set_port(0, 4'd0, 32'h1);
        tick();
        clr();
        chk("mid_pre_valid", 32'(alu_valid), 1);
        chk("mid_pre_data", data_of(3) != 0, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(alu_valid), 0);
        chk("mid_cmd", 32'(alu_cmd), 0);
        chk("mid_op1", alu_op1, 0);
        chk("mid_data", out_data == '0, 1);
        tick();
        reset     = 1'b0;
        alu_ready = 1'b1;
        rsp(3, 2'd1, 32'hDEAD);
        chk("late_resp", 32'(out_resp), 0);
        chk("late_data", data_of(3), 0);
        tick();
        chk("late_resp2", 32'(out_resp), 0);
        chk("late_valid", 32'(alu_valid), 0);

        // Unsupported command code 3 on port3.
        tick();
        issue_cnt = 0;
        set_port(2, 4'd3, 32'h5);
        tick();
        set_port(2, 4'd0, 32'h6);
        tick();
        clr();
`ifdef CALC1_SCHED_INVALID_CMD_EN
        chk("inv_valid", 32'(alu_valid), 0);
        chk("inv_resp", 32'(out_resp), 32'(8'h2 << 4));
        chk("inv_data", data_of(2), 0);
        tick();
        chk("inv_pulse", 32'(out_resp), 0);
        chk("inv_issues", 32'(issue_cnt), 0);
`else
        chk("inv_valid", 32'(alu_valid), 1);
        chk("inv_cmd", 32'(alu_cmd), 3);
        chk("inv_tag", 32'(alu_tag), 2);
        tick();
        rsp(2, 2'd1, 32'h33);
        chk("inv_resp", 32'(resp_of(2)), 1);
        chk("inv_data", data_of(2), 32'h33);
`endif

        // Randomized run against the transaction model.
        do_reset();
        m_ptr  = 0;
        m_lock = 1'b0;
        m_lidx = 0;
        for (int p = 0; p < NP; p++) begin
            m_st[p]   = 0;
            e_resp[p] = 2'd0;
            e_data[p] = 32'd0;
        end
        aq.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int          eg;
            int          nst [NP];
            logic [3:0]  dc [NP];
            logic [31:0] dd [NP];
            int          hit;

            eg = -1;
            if (m_lock) begin
                eg = m_lidx;
            end else begin
                for (int k = 0; k < NP; k++) begin
                    if (eg < 0 && m_st[(m_ptr + k) % NP] == 2) begin
                        eg = (m_ptr + k) % NP;
                    end
                end
            end
            chk("rnd_valid", 32'(alu_valid), 32'(eg >= 0));
            if (eg >= 0) begin
                chk("rnd_tag", 32'(alu_tag), 32'(eg));
                chk("rnd_cmd", 32'(alu_cmd), 32'(m_cmd[eg]));
                chk("rnd_op1", alu_op1, m_op1[eg]);
                chk("rnd_op2", alu_op2, m_op2[eg]);
            end
            for (int p = 0; p < NP; p++) begin
                chk("rnd_resp", 32'(resp_of(p)), 32'(e_resp[p]));
                chk("rnd_data", data_of(p), e_data[p]);
            end

            alu_ready = ($urandom_range(0, 3) != 0);
            hit = -1;
            for (int j = 0; j < aq.size(); j++) begin
                if (hit < 0 && aq[j].due <= cyc) hit = j;
            end
            if (hit >= 0) begin
                alu_rsp_valid = 1'b1;
                alu_rsp_tag   = 2'(aq[hit].tag);
                alu_rsp_code  = aq[hit].code;
                alu_rsp_data  = aq[hit].data;
            end else begin
                alu_rsp_valid = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                dd[p] = $urandom;
                dc[p] = 4'd0;
                if (m_st[p] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        case ($urandom_range(0, 3))
                            0: dc[p] = 4'd1;
                            1: dc[p] = 4'd2;
                            2: dc[p] = 4'd5;
                            default: dc[p] = 4'd6;
                        endcase
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    dc[p] = 4'($urandom_range(1, 15));
                end
                set_port(p, dc[p], dd[p]);
            end

            for (int p = 0; p < NP; p++) begin
                nst[p]    = m_st[p];
                e_resp[p] = 2'd0;
            end
            if (eg >= 0 && alu_ready) begin
                rsp_t r;
                r.tag  = eg;
                r.due  = cyc + $urandom_range(1, 4);
                r.code = 2'($urandom_range(1, 2));
                r.data = $urandom;
                aq.push_back(r);
                nst[eg] = 3;
                m_ptr   = (eg + 1) % NP;
                m_lock  = 1'b0;
            end else begin
                m_lock = (eg >= 0);
                m_lidx = eg;
            end
            if (hit >= 0) begin
                if (m_st[aq[hit].tag] == 3) begin
                    e_resp[aq[hit].tag] = aq[hit].code;
                    e_data[aq[hit].tag] = aq[hit].data;
                    nst[aq[hit].tag]    = 0;
                end
                aq.delete(hit);
            end
            for (int p = 0; p < NP; p++) begin
                if (m_st[p] == 0 && dc[p] != 4'd0) begin
                    m_cmd[p] = dc[p];
                    m_op1[p] = dd[p];
                    nst[p]   = 1;
                end else if (m_st[p] == 1) begin
                    m_op2[p] = dd[p];
                    nst[p]   = 2;
                end
            end
            for (int p = 0; p < NP; p++) m_st[p] = nst[p];
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
